// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-subtract step per cycle on operand magnitudes; signs are fixed up on the last step.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic             is_div_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             div_zero_reg;
  logic [WIDTH-1:0] operand_reg;
  logic [WIDTH-1:0] rs_reg;
  logic [WIDTH-1:0] work_hi_reg;
  logic [WIDTH-1:0] work_lo_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             done_reg;

  logic             op_mul, op_div, op_signed, accept, last_step;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign accept    = (state_reg == IDLE) && start && !flush && (op_mul || op_div);
  assign last_step = (state_reg == CALC) && !flush && (count_reg == CW'(1));

  assign rs_neg = op_signed && rs[WIDTH-1];
  assign rt_neg = op_signed && rt[WIDTH-1];
  assign rs_mag = rs_neg ? -rs : rs;
  assign rt_mag = rt_neg ? -rt : rt;

  // Multiply step: conditionally add multiplicand into the upper half, then shift the pair right.
  logic [WIDTH:0]   mul_addend, mul_sum;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next;

  assign mul_addend  = work_lo_reg[0] ? {1'b0, operand_reg} : '0;
  assign mul_sum     = {1'b0, work_hi_reg} + mul_addend;
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], work_lo_reg[WIDTH-1:1]};

  // Divide step: remainder in the upper half, dividend shifting out of / quotient into the lower half.
  logic [WIDTH:0]   div_shifted, div_diff;
  logic [WIDTH-1:0] div_hi_next, div_lo_next;

  assign div_shifted = {work_hi_reg, work_lo_reg[WIDTH-1]};
  assign div_diff    = div_shifted - {1'b0, operand_reg};
  assign div_hi_next = div_diff[WIDTH] ? div_shifted[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign div_lo_next = {work_lo_reg[WIDTH-2:0], ~div_diff[WIDTH]};

  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed;
  logic [WIDTH-1:0]   final_hi, final_lo;

  assign step_hi    = is_div_reg ? div_hi_next : mul_hi_next;
  assign step_lo    = is_div_reg ? div_lo_next : mul_lo_next;
  assign prod_fixed = neg_q_reg ? -{step_hi, step_lo} : {step_hi, step_lo};
  assign quo_fixed  = neg_q_reg ? -step_lo : step_lo;
  assign rem_fixed  = neg_r_reg ? -step_hi : step_hi;

  always_comb begin
    final_hi = prod_fixed[2*WIDTH-1:WIDTH];
    final_lo = prod_fixed[WIDTH-1:0];
    if (is_div_reg) begin
      // A zero divisor returns the raw dividend rather than a sign-fixed remainder.
      if (div_zero_reg) begin
        final_hi = rs_reg;
        final_lo = '1;
      end else begin
        final_hi = rem_fixed;
        final_lo = quo_fixed;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (flush || last_step) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg    <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      operand_reg  <= '0;
      rs_reg       <= '0;
      work_hi_reg  <= '0;
      work_lo_reg  <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == IDLE) begin
        if (accept) begin
          count_reg    <= CW'(WIDTH);
          is_div_reg   <= op_div;
          neg_q_reg    <= rs_neg ^ rt_neg;
          neg_r_reg    <= rs_neg;
          div_zero_reg <= op_div && (rt == '0);
          operand_reg  <= op_div ? rt_mag : rs_mag;
          rs_reg       <= rs;
          work_hi_reg  <= '0;
          work_lo_reg  <= op_div ? rs_mag : rt_mag;
        end else if (start && !flush && op == OP_MTHI) begin
          hi_reg <= rs;
        end else if (start && !flush && op == OP_MTLO) begin
          lo_reg <= rs;
        end
      end else if (flush) begin
        count_reg <= '0;
      end else begin
        work_hi_reg <= step_hi;
        work_lo_reg <= step_lo;
        count_reg   <= count_reg - CW'(1);
        if (last_step) begin
          hi_reg   <= final_hi;
          lo_reg   <= final_lo;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign hi   = hi_reg;
  assign lo   = lo_reg;
  assign busy = (state_reg == CALC);
  assign done = done_reg;

endmodule
